// File: rtl/multi_port_mem_arbiter.sv
// Round-robin arbiter for N_CH requesters onto one 16-bit memory port.
// One access in flight; byte/word lanes, range/alignment checks, read timeout.
module multi_port_mem_arbiter #(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned MEM_DEPTH  = 32768,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RD_TIMEOUT = 255,
  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_en     [0:N_CH-1],
  input  logic              req_wr     [0:N_CH-1],
  input  logic              req_size   [0:N_CH-1],
  input  logic [ADDR_W-1:0] req_addr   [0:N_CH-1],
  input  logic [15:0]       req_wdata  [0:N_CH-1],
  output logic              resp_done  [0:N_CH-1],
  output logic              resp_err   [0:N_CH-1],
  output logic [15:0]       resp_rdata [0:N_CH-1],
  output logic              busy,
  output logic              mem_rd_en,
  output logic [1:0]        mem_wr_en,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_rd_done,
  input  logic [15:0]       mem_rd_data
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned TO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              size_q, size_d;
  logic              lsb_q, lsb_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [1:0]        mem_wr_en_q, mem_wr_en_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              resp_done_q  [0:N_CH-1];
  logic              resp_done_d  [0:N_CH-1];
  logic              resp_err_q   [0:N_CH-1];
  logic              resp_err_d   [0:N_CH-1];
  logic [15:0]       resp_rdata_q [0:N_CH-1];
  logic [15:0]       resp_rdata_d [0:N_CH-1];

  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   cand;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wr;
  logic              sel_size;
  logic [15:0]       sel_wdata;
  logic              sel_err;
  logic [15:0]       rd_word;
  logic              rd_tmo;

  // search starts one past the last winner, so every channel gets a turn
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = rr_q;
    cand    = rr_q;
    for (int k = 1; k <= int'(N_CH); k++) begin
      cand = CH_W'((int'(rr_q) + k) % int'(N_CH));
      if (!gnt_vld && req_en[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = req_addr[gnt_ch];
    sel_wr    = req_wr[gnt_ch];
    sel_size  = req_size[gnt_ch];
    sel_wdata = req_wdata[gnt_ch];
    sel_err   = (sel_size && sel_addr[0]) ||
                (32'(sel_addr[ADDR_W-1:1]) >= MEM_DEPTH);
  end

  always_comb begin
    if (size_q) begin
      rd_word = mem_rd_data;
    end else if (lsb_q) begin
      rd_word = {8'h00, mem_rd_data[15:8]};
    end else begin
      rd_word = {8'h00, mem_rd_data[7:0]};
    end
    rd_tmo = (RD_TIMEOUT != 0) &&
             (32'(cnt_q) + 32'd1 == RD_TIMEOUT);
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    size_d      = size_q;
    lsb_d       = lsb_q;
    cnt_d       = cnt_q;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 2'b00;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      resp_done_d[i]  = 1'b0;
      resp_err_d[i]   = 1'b0;
      resp_rdata_d[i] = 16'h0000;
    end
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          rr_d   = gnt_ch;
          size_d = sel_size;
          lsb_d  = sel_addr[0];
          if (sel_err) begin
            state_d             = S_RESP;
            resp_done_d[gnt_ch] = 1'b1;
            resp_err_d[gnt_ch]  = 1'b1;
          end else if (sel_wr) begin
            state_d    = S_WRITE;
            mem_addr_d = sel_addr[MEM_AW:1];
            if (sel_size) begin
              mem_wr_en_d = 2'b11;
              mem_wdata_d = sel_wdata;
            end else begin
              mem_wr_en_d = sel_addr[0] ? 2'b10 : 2'b01;
              mem_wdata_d = {sel_wdata[7:0], sel_wdata[7:0]};
            end
          end else begin
            state_d     = S_READ;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = sel_addr[MEM_AW:1];
            cnt_d       = '0;
          end
        end
      end
      S_WRITE: begin
        state_d           = S_RESP;
        resp_done_d[rr_q] = 1'b1;
      end
      S_READ: begin
        if (mem_rd_done) begin
          state_d            = S_RESP;
          resp_done_d[rr_q]  = 1'b1;
          resp_rdata_d[rr_q] = rd_word;
        end else if (rd_tmo) begin
          state_d           = S_RESP;
          resp_done_d[rr_q] = 1'b1;
          resp_err_d[rr_q]  = 1'b1;
        end else begin
          mem_rd_en_d = 1'b1;
          cnt_d       = cnt_q + TO_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= CH_W'(N_CH - 1);
      size_q      <= 1'b0;
      lsb_q       <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      for (int i = 0; i < int'(N_CH); i++) begin
        resp_done_q[i]  <= 1'b0;
        resp_err_q[i]   <= 1'b0;
        resp_rdata_q[i] <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      size_q      <= size_d;
      lsb_q       <= lsb_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        resp_done_q[i]  <= resp_done_d[i];
        resp_err_q[i]   <= resp_err_d[i];
        resp_rdata_q[i] <= resp_rdata_d[i];
      end
    end
  end

  assign busy       = busy_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_done  = resp_done_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
